// File: rtl/tick_divider_if.sv
`default_nettype none
// ============================================================================
//  Module      : tick_divider_if
//  Description : Control/status bundle for the tick divider (bench drives
//                the master side, the divider is the slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface tick_divider_if #(
    parameter int WIDTH = 16
);
    logic             en;
    logic             sync_clr;
    logic [WIDTH-1:0] div_value;
    logic             div_load;
    logic             div_busy;
    logic             tick;
    logic             clk_out;
    logic [WIDTH-1:0] count;

    modport master (
        output en, sync_clr, div_value, div_load,
        input  div_busy, tick, clk_out, count
    );

    modport slave (
        input  en, sync_clr, div_value, div_load,
        output div_busy, tick, clk_out, count
    );
endinterface
`default_nettype wire

// File: rtl/tick_divider.sv
`default_nettype none
// ============================================================================
//  Module      : tick_divider
//  Description : Runtime-programmable clock-enable divider producing a
//                one-cycle tick strobe and a registered square wave.
//  Revision    : 1.0 - initial release
// ============================================================================
module tick_divider #(
    parameter int WIDTH       = 16,
    parameter int DEFAULT_DIV = 4
) (
    input  wire logic     clk,
    input  wire logic     rst,
    tick_divider_if.slave bus
);

    localparam logic [WIDTH-1:0] c_default_div = WIDTH'(DEFAULT_DIV);
    localparam logic [WIDTH-1:0] c_one         = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH:0]   c_one_ext     = {{WIDTH{1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] r_div;
    logic [WIDTH-1:0] r_pend;
    logic             r_busy;
    logic             r_tick;
    logic             r_clk_out;

    logic             w_pend_valid;
    logic [WIDTH-1:0] w_pend_val;
    logic [WIDTH-1:0] w_next_div;
    logic [WIDTH-1:0] w_count_inc;
    logic [WIDTH:0]   w_cur_half;
    logic [WIDTH:0]   w_next_half;
    logic             w_at_tc;

    // A load on the applying edge wins over the stored pending value.
    always_comb begin
        w_pend_valid = bus.div_load | r_busy;
        w_pend_val   = bus.div_load ? bus.div_value : r_pend;
        w_next_div   = w_pend_valid ? w_pend_val : r_div;
        w_count_inc  = r_count + c_one;
        w_cur_half   = ({1'b0, r_div} + c_one_ext) >> 1;
        w_next_half  = ({1'b0, w_next_div} + c_one_ext) >> 1;
        w_at_tc      = (r_div != '0) && (r_count == (r_div - c_one));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count   <= '0;
            r_div     <= c_default_div;
            r_pend    <= '0;
            r_busy    <= 1'b0;
            r_tick    <= 1'b0;
            r_clk_out <= 1'b0;
        end else if (bus.sync_clr) begin
            r_count   <= '0;
            r_tick    <= 1'b0;
            r_div     <= w_next_div;
            r_busy    <= 1'b0;
            r_clk_out <= (w_next_div != '0);
        end else if (r_div == '0) begin
            // Stopped: outputs parked low, any pending divisor takes over now.
            r_count   <= '0;
            r_tick    <= 1'b0;
            r_clk_out <= 1'b0;
            r_div     <= w_next_div;
            r_busy    <= 1'b0;
        end else if (bus.en) begin
            if (w_at_tc) begin
                r_count   <= '0;
                r_tick    <= 1'b1;
                r_div     <= w_next_div;
                r_busy    <= 1'b0;
                r_clk_out <= (w_next_half != '0);
            end else begin
                r_count   <= w_count_inc;
                r_tick    <= 1'b0;
                r_clk_out <= ({1'b0, w_count_inc} < w_cur_half);
                if (bus.div_load) begin
                    r_pend <= bus.div_value;
                    r_busy <= 1'b1;
                end
            end
        end else begin
            r_tick <= 1'b0;
            if (bus.div_load) begin
                r_pend <= bus.div_value;
                r_busy <= 1'b1;
            end
        end
    end

    assign bus.count    = r_count;
    assign bus.tick     = r_tick;
    assign bus.clk_out  = r_clk_out;
    assign bus.div_busy = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_tick_divider.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tick_divider
//  Description : Directed self-checking bench for tick_divider.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_tick_divider;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;

    logic [15:0] e_cnt;
    logic        e_tick;
    logic        e_clk;
    logic        e_busy;
    int          highs;

    tick_divider_if #(.WIDTH(16)) bus ();

    tick_divider #(
        .WIDTH      (16),
        .DEFAULT_DIV(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge and settle before sampling / driving.
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; bus.en = 1'b0; bus.sync_clr = 1'b0;
        bus.div_load = 1'b0; bus.div_value = '0;
        cycle(); cycle();
        e_cnt = 0; e_tick = 0; e_clk = 0; e_busy = 0;
        n_cmp++;
        if ({bus.count, bus.tick, bus.clk_out, bus.div_busy} !== {e_cnt, e_tick, e_clk, e_busy}) begin
            n_bad++;
            $display("FAIL reset: got cnt=%0d tick=%b clk_out=%b busy=%b, want cnt=%0d tick=%b clk_out=%b busy=%b",
                     bus.count, bus.tick, bus.clk_out, bus.div_busy, e_cnt, e_tick, e_clk, e_busy);
        end
        rst = 1'b0;
        cycle();
        n_cmp++;
        if ({bus.count, bus.tick, bus.clk_out, bus.div_busy} !== {e_cnt, e_tick, e_clk, e_busy}) begin
            n_bad++;
            $display("FAIL idle_after_reset: got cnt=%0d tick=%b clk_out=%b busy=%b, want cnt=%0d tick=%b clk_out=%b busy=%b",
                     bus.count, bus.tick, bus.clk_out, bus.div_busy, e_cnt, e_tick, e_clk, e_busy);
        end
    endtask

    task automatic test_basic();
        bus.en = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            cycle();
            e_cnt = 16'(i % 4); e_tick = (i % 4 == 0); e_clk = (e_cnt < 2); e_busy = 0;
            n_cmp++;
            if ({bus.count, bus.tick, bus.clk_out, bus.div_busy} !== {e_cnt, e_tick, e_clk, e_busy}) begin
                n_bad++;
                $display("FAIL basic_div4[%0d]: got cnt=%0d tick=%b clk_out=%b busy=%b, want cnt=%0d tick=%b clk_out=%b busy=%b",
                         i, bus.count, bus.tick, bus.clk_out, bus.div_busy, e_cnt, e_tick, e_clk, e_busy);
            end
        end
    endtask

    task automatic test_reload();
        cycle();
        bus.div_load = 1'b1; bus.div_value = 16'd5;
        cycle();
        bus.div_load = 1'b0;
        for (int i = 0; i < 3; i++) begin
            // count 2, 3 with busy held, then the wrap applies D=5
            e_cnt = (i == 2) ? 16'd0 : 16'(i + 2);
            e_tick = (i == 2); e_clk = (i == 2); e_busy = (i != 2);
            n_cmp++;
            if ({bus.count, bus.tick, bus.clk_out, bus.div_busy} !== {e_cnt, e_tick, e_clk, e_busy}) begin
                n_bad++;
                $display("FAIL reload_pending[%0d]: got cnt=%0d tick=%b clk_out=%b busy=%b, want cnt=%0d tick=%b clk_out=%b busy=%b",
                         i, bus.count, bus.tick, bus.clk_out, bus.div_busy, e_cnt, e_tick, e_clk, e_busy);
            end
            if (i < 2) cycle();
        end
        highs = 0;
        for (int i = 1; i <= 5; i++) begin
            cycle();
            e_cnt = 16'(i % 5); e_tick = (i == 5); e_clk = (e_cnt < 3); e_busy = 0;
            if (bus.clk_out === 1'b1) highs++;
            n_cmp++;
            if ({bus.count, bus.tick, bus.clk_out, bus.div_busy} !== {e_cnt, e_tick, e_clk, e_busy}) begin
                n_bad++;
                $display("FAIL div5_period[%0d]: got cnt=%0d tick=%b clk_out=%b busy=%b, want cnt=%0d tick=%b clk_out=%b busy=%b",
                         i, bus.count, bus.tick, bus.clk_out, bus.div_busy, e_cnt, e_tick, e_clk, e_busy);
            end
        end
        n_cmp++;
        if (highs !== 3) begin
            n_bad++;
            $display("FAIL div5_duty: got high=%0d, want high=3", highs);
        end
    endtask

    task automatic test_clr_load();
        bus.sync_clr = 1'b1; bus.div_load = 1'b1; bus.div_value = 16'd4;
        cycle();
        bus.sync_clr = 1'b0; bus.div_load = 1'b0;
        e_cnt = 0; e_tick = 0; e_clk = 1; e_busy = 0;
        n_cmp++;
        if ({bus.count, bus.tick, bus.clk_out, bus.div_busy} !== {e_cnt, e_tick, e_clk, e_busy}) begin
            n_bad++;
            $display("FAIL clr_with_load: got cnt=%0d tick=%b clk_out=%b busy=%b, want cnt=%0d tick=%b clk_out=%b busy=%b",
                     bus.count, bus.tick, bus.clk_out, bus.div_busy, e_cnt, e_tick, e_clk, e_busy);
        end
    endtask

    task automatic test_pause();
        for (int i = 1; i <= 7; i++) begin
            bus.en = !(i >= 3 && i <= 5);
            cycle();
            // counts 1,2 | frozen at 2 for three edges | 3,0
            case (i)
                1:       begin e_cnt = 1; e_tick = 0; e_clk = 1; end
                6:       begin e_cnt = 3; e_tick = 0; e_clk = 0; end
                7:       begin e_cnt = 0; e_tick = 1; e_clk = 1; end
                default: begin e_cnt = 2; e_tick = 0; e_clk = 0; end
            endcase
            e_busy = 0;
            n_cmp++;
            if ({bus.count, bus.tick, bus.clk_out, bus.div_busy} !== {e_cnt, e_tick, e_clk, e_busy}) begin
                n_bad++;
                $display("FAIL pause[%0d]: got cnt=%0d tick=%b clk_out=%b busy=%b, want cnt=%0d tick=%b clk_out=%b busy=%b",
                         i, bus.count, bus.tick, bus.clk_out, bus.div_busy, e_cnt, e_tick, e_clk, e_busy);
            end
        end
        bus.en = 1'b1;
    endtask

    task automatic test_sync_clr();
        bus.div_load = 1'b1; bus.div_value = 16'd6;
        cycle();
        bus.div_load = 1'b0;
        cycle();
        e_cnt = 2; e_tick = 0; e_clk = 0; e_busy = 1;
        n_cmp++;
        if ({bus.count, bus.tick, bus.clk_out, bus.div_busy} !== {e_cnt, e_tick, e_clk, e_busy}) begin
            n_bad++;
            $display("FAIL pending6: got cnt=%0d tick=%b clk_out=%b busy=%b, want cnt=%0d tick=%b clk_out=%b busy=%b",
                     bus.count, bus.tick, bus.clk_out, bus.div_busy, e_cnt, e_tick, e_clk, e_busy);
        end
        bus.sync_clr = 1'b1;
        cycle();
        bus.sync_clr = 1'b0;
        e_cnt = 0; e_tick = 0; e_clk = 1; e_busy = 0;
        n_cmp++;
        if ({bus.count, bus.tick, bus.clk_out, bus.div_busy} !== {e_cnt, e_tick, e_clk, e_busy}) begin
            n_bad++;
            $display("FAIL sync_clr_apply: got cnt=%0d tick=%b clk_out=%b busy=%b, want cnt=%0d tick=%b clk_out=%b busy=%b",
                     bus.count, bus.tick, bus.clk_out, bus.div_busy, e_cnt, e_tick, e_clk, e_busy);
        end
        for (int i = 1; i <= 6; i++) begin
            cycle();
            e_cnt = 16'(i % 6); e_tick = (i == 6); e_clk = (e_cnt < 3); e_busy = 0;
            n_cmp++;
            if ({bus.count, bus.tick, bus.clk_out, bus.div_busy} !== {e_cnt, e_tick, e_clk, e_busy}) begin
                n_bad++;
                $display("FAIL div6_period[%0d]: got cnt=%0d tick=%b clk_out=%b busy=%b, want cnt=%0d tick=%b clk_out=%b busy=%b",
                         i, bus.count, bus.tick, bus.clk_out, bus.div_busy, e_cnt, e_tick, e_clk, e_busy);
            end
        end
    endtask

    task automatic test_zero();
        bus.div_load = 1'b1; bus.div_value = 16'd0;
        for (int i = 1; i <= 6; i++) begin
            cycle();
            bus.div_load = 1'b0;
            // counts 1..5 with D=6 pending 0, then wrap into the stopped state
            e_cnt = 16'(i % 6); e_tick = (i == 6); e_clk = (i <= 2); e_busy = (i != 6);
            n_cmp++;
            if ({bus.count, bus.tick, bus.clk_out, bus.div_busy} !== {e_cnt, e_tick, e_clk, e_busy}) begin
                n_bad++;
                $display("FAIL load_zero[%0d]: got cnt=%0d tick=%b clk_out=%b busy=%b, want cnt=%0d tick=%b clk_out=%b busy=%b",
                         i, bus.count, bus.tick, bus.clk_out, bus.div_busy, e_cnt, e_tick, e_clk, e_busy);
            end
        end
        e_cnt = 0; e_tick = 0; e_clk = 0; e_busy = 0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            n_cmp++;
            if ({bus.count, bus.tick, bus.clk_out, bus.div_busy} !== {e_cnt, e_tick, e_clk, e_busy}) begin
                n_bad++;
                $display("FAIL stopped[%0d]: got cnt=%0d tick=%b clk_out=%b busy=%b, want cnt=%0d tick=%b clk_out=%b busy=%b",
                         i, bus.count, bus.tick, bus.clk_out, bus.div_busy, e_cnt, e_tick, e_clk, e_busy);
            end
        end
        bus.en = 1'b0; bus.div_load = 1'b1; bus.div_value = 16'd3;
        cycle();
        bus.div_load = 1'b0; bus.en = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            cycle();
            e_cnt = 16'(i % 3); e_tick = (i == 3); e_clk = (e_cnt < 2); e_busy = 0;
            n_cmp++;
            if ({bus.count, bus.tick, bus.clk_out, bus.div_busy} !== {e_cnt, e_tick, e_clk, e_busy}) begin
                n_bad++;
                $display("FAIL div3_after_stop[%0d]: got cnt=%0d tick=%b clk_out=%b busy=%b, want cnt=%0d tick=%b clk_out=%b busy=%b",
                         i, bus.count, bus.tick, bus.clk_out, bus.div_busy, e_cnt, e_tick, e_clk, e_busy);
            end
        end
    endtask

    task automatic test_reset_mid();
        cycle();
        bus.en = 1'b0; bus.div_load = 1'b1; bus.div_value = 16'd7;
        cycle();
        bus.div_value = 16'd9;
        cycle();
        bus.div_load = 1'b0;
        e_cnt = 1; e_tick = 0; e_clk = 1; e_busy = 1;
        n_cmp++;
        if ({bus.count, bus.tick, bus.clk_out, bus.div_busy} !== {e_cnt, e_tick, e_clk, e_busy}) begin
            n_bad++;
            $display("FAIL double_load: got cnt=%0d tick=%b clk_out=%b busy=%b, want cnt=%0d tick=%b clk_out=%b busy=%b",
                     bus.count, bus.tick, bus.clk_out, bus.div_busy, e_cnt, e_tick, e_clk, e_busy);
        end
        rst = 1'b1;
        cycle();
        rst = 1'b0; bus.en = 1'b1;
        e_cnt = 0; e_tick = 0; e_clk = 0; e_busy = 0;
        n_cmp++;
        if ({bus.count, bus.tick, bus.clk_out, bus.div_busy} !== {e_cnt, e_tick, e_clk, e_busy}) begin
            n_bad++;
            $display("FAIL reset_mid: got cnt=%0d tick=%b clk_out=%b busy=%b, want cnt=%0d tick=%b clk_out=%b busy=%b",
                     bus.count, bus.tick, bus.clk_out, bus.div_busy, e_cnt, e_tick, e_clk, e_busy);
        end
        for (int i = 1; i <= 4; i++) begin
            cycle();
            e_cnt = 16'(i % 4); e_tick = (i == 4); e_clk = (e_cnt < 2); e_busy = 0;
            n_cmp++;
            if ({bus.count, bus.tick, bus.clk_out, bus.div_busy} !== {e_cnt, e_tick, e_clk, e_busy}) begin
                n_bad++;
                $display("FAIL default_after_reset[%0d]: got cnt=%0d tick=%b clk_out=%b busy=%b, want cnt=%0d tick=%b clk_out=%b busy=%b",
                         i, bus.count, bus.tick, bus.clk_out, bus.div_busy, e_cnt, e_tick, e_clk, e_busy);
            end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_basic();
        test_reload();
        test_clr_load();
        test_pause();
        test_sync_clr();
        test_zero();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
